// File: rtl/cpu_fpu_pkg.sv
// cpu_fpu_pkg: shared fused-op enum, fflags bit indices and single-precision field constants
package cpu_fpu_pkg;
  typedef enum logic [1:0] {FMADD, FMSUB, FNMSUB, FNMADD} fused_op_e;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [7:0] EXP_MAX = 8'd255;
  localparam int QNAN_BIT = 22;
  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
endpackage

// File: rtl/cpu_fpu_classify.sv
// cpu_fpu_classify: combinational single-precision classifier (x -> is_zero, is_inf, is_nan, is_snan)
module cpu_fpu_classify
  import cpu_fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan
);
  logic exp_max, mant_nz;
  assign exp_max = x[30:23] == EXP_MAX;
  assign mant_nz = |x[22:0];
  assign is_zero = ~|x[30:0];
  assign is_inf  = exp_max & ~mant_nz;
  assign is_nan  = exp_max & mant_nz;
  assign is_snan = is_nan & ~x[QNAN_BIT];
endmodule

// File: rtl/cpu_fpu_fused_issue.sv
// cpu_fpu_fused_issue: fused multiply-add sequencer; upstream i_request/i_op/i_rs1..3 -> o_ready/o_result (NaN canonicalised), downstream o_fma_request/o_fma_op1..3 <- i_fma_ready/i_fma_result, o_fflags only with FFLAGS_EN
module cpu_fpu_fused_issue
  import cpu_fpu_pkg::*;
#(
  parameter logic [31:0] CANONICAL_NAN = cpu_fpu_pkg::CANONICAL_NAN
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rs3,
  output logic        o_ready,
  output logic [31:0] o_result,
`ifdef FFLAGS_EN
  output logic [4:0]  o_fflags,
`endif
  output logic        o_fma_request,
  output logic [31:0] o_fma_op1,
  output logic [31:0] o_fma_op2,
  output logic [31:0] o_fma_op3,
  input  logic        i_fma_ready,
  input  logic [31:0] i_fma_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_e;
  state_e state;
  fused_op_e op;
  logic neg_prod, neg_add;
  logic [31:0] res;
  logic res_zero, res_inf, res_nan, res_snan;
  assign op = fused_op_e'(i_op);
  assign neg_prod = op inside {FNMSUB, FNMADD};
  assign neg_add = op inside {FMSUB, FNMADD};
  cpu_fpu_classify u_res (
    .x(res),
    .is_zero(res_zero),
    .is_inf(res_inf),
    .is_nan(res_nan),
    .is_snan(res_snan)
  );
`ifdef FFLAGS_EN
  logic [2:0][31:0] ops;
  logic [2:0] op_zero, op_inf, op_nan, op_snan;
  logic prod_inf, nv;
  logic [4:0] flags;
  logic unused;
  assign ops = {o_fma_op3, o_fma_op2, o_fma_op1};
  for (genvar i = 0; i < 3; i++) begin : g_cls
    cpu_fpu_classify u_cls (
      .x(ops[i]),
      .is_zero(op_zero[i]),
      .is_inf(op_inf[i]),
      .is_nan(op_nan[i]),
      .is_snan(op_snan[i])
    );
  end
  assign prod_inf = (op_inf[0] | op_inf[1]) & ~|op_nan[1:0];
  assign nv = |op_snan | (op_inf[0] & op_zero[1]) | (op_zero[0] & op_inf[1])
            | (prod_inf & op_inf[2] & (o_fma_op1[31] ^ o_fma_op2[31] ^ o_fma_op3[31]));
  always_comb begin
    flags = '0;
    flags[FLAG_NV] = nv;
    flags[FLAG_OF] = res_inf & ~|op_inf;
  end
  assign unused = ^{res_zero, res_snan, op_zero[2]};
`else
  logic unused;
  assign unused = ^{res_zero, res_inf, res_snan};
`endif
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      o_ready <= 1'b0;
      o_result <= '0;
      o_fma_request <= 1'b0;
      o_fma_op1 <= '0;
      o_fma_op2 <= '0;
      o_fma_op3 <= '0;
      res <= '0;
`ifdef FFLAGS_EN
      o_fflags <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (i_request) begin
          o_fma_op1 <= {i_rs1[31] ^ neg_prod, i_rs1[30:0]};
          o_fma_op2 <= i_rs2;
          o_fma_op3 <= {i_rs3[31] ^ neg_add, i_rs3[30:0]};
          o_fma_request <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (i_fma_ready) begin
          res <= i_fma_result;
          o_fma_request <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: if (!i_fma_ready) begin
          o_ready <= 1'b1;
          o_result <= res_nan ? CANONICAL_NAN : res;
`ifdef FFLAGS_EN
          o_fflags <= flags;
`endif
          state <= DONE;
        end
        DONE: if (!i_request) begin
          o_ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_fpu_fused_issue.sv
// tb_cpu_fpu_fused_issue: directed vectors against a spec-level model of the fused-op sequencer
module tb_cpu_fpu_fused_issue;
  logic i_clock = 1'b0, i_reset = 1'b1, i_request = 1'b0, i_fma_ready = 1'b0;
  logic [1:0] i_op = '0;
  logic [31:0] i_rs1 = '0, i_rs2 = '0, i_rs3 = '0, i_fma_result = '0;
  logic o_ready, o_fma_request;
  logic [31:0] o_result, o_fma_op1, o_fma_op2, o_fma_op3;
`ifdef FFLAGS_EN
  logic [4:0] o_fflags;
`endif
  int vecs = 0, errs = 0;
  logic [31:0] exp_op1 = '0, exp_op2 = '0, exp_op3 = '0, exp_res = '0;
  logic prev_ready = 1'b0;
  logic [31:0] g1, g3, gr;
  cpu_fpu_fused_issue dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_request(i_request),
    .i_op(i_op),
    .i_rs1(i_rs1),
    .i_rs2(i_rs2),
    .i_rs3(i_rs3),
    .o_ready(o_ready),
    .o_result(o_result),
`ifdef FFLAGS_EN
    .o_fflags(o_fflags),
`endif
    .o_fma_request(o_fma_request),
    .o_fma_op1(o_fma_op1),
    .o_fma_op2(o_fma_op2),
    .o_fma_op3(o_fma_op3),
    .i_fma_ready(i_fma_ready),
    .i_fma_result(i_fma_result)
  );
  always #5 i_clock = ~i_clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [31:0] model_result(input logic [31:0] r);
    return (r[30:23] == 8'hFF && r[22:0] != 0) ? 32'h7FC0_0000 : r;
  endfunction
  always @(posedge i_clock) prev_ready <= i_fma_ready;
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_fma_request) begin
        chk("op1", o_fma_op1, exp_op1);
        chk("op2", o_fma_op2, exp_op2);
        chk("op3", o_fma_op3, exp_op3);
        chk("req_after_ready", {31'b0, prev_ready}, 32'd0);
      end
      if (o_ready) chk("result", o_result, exp_res);
    end
  end
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, b, c, r,
                        input int delay, hold, keep, input bit drop_early,
                        output logic [31:0] got1, got3, gotr);
    @(negedge i_clock);
    i_op = op; i_rs1 = a; i_rs2 = b; i_rs3 = c; i_request = 1'b1;
    exp_op1 = a ^ ((op == 2'd2 || op == 2'd3) ? 32'h8000_0000 : 32'h0);
    exp_op2 = b;
    exp_op3 = c ^ ((op == 2'd1 || op == 2'd3) ? 32'h8000_0000 : 32'h0);
    exp_res = model_result(r);
    @(negedge i_clock);
    chk("req_rise", {31'b0, o_fma_request}, 32'd1);
    chk("ready_idle", {31'b0, o_ready}, 32'd0);
    got1 = o_fma_op1; got3 = o_fma_op3;
    if (drop_early) i_request = 1'b0;
    repeat (delay) begin
      @(negedge i_clock);
      chk("req_hold", {31'b0, o_fma_request}, 32'd1);
    end
    i_fma_ready = 1'b1; i_fma_result = r;
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clock);
      i_fma_result = ~r;
      chk("req_low_in_release", {31'b0, o_fma_request}, 32'd0);
      chk("no_early_ready", {31'b0, o_ready}, 32'd0);
    end
    i_fma_ready = 1'b0;
    @(negedge i_clock);
    chk("ready_rise", {31'b0, o_ready}, 32'd1);
    gotr = o_result;
    if (!drop_early) begin
      repeat (keep) begin
        @(negedge i_clock);
        chk("ready_hold", {31'b0, o_ready}, 32'd1);
      end
    end
    i_request = 1'b0;
    @(negedge i_clock);
    chk("ready_fall", {31'b0, o_ready}, 32'd0);
  endtask
  initial begin
    i_request = 1'b1; i_op = 2'd3; i_rs1 = 32'h1234_5678; i_rs2 = 32'h9ABC_DEF0; i_rs3 = 32'h0F0F_0F0F;
    repeat (2) @(negedge i_clock);
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_req", {31'b0, o_fma_request}, 32'd0);
    chk("rst_op1", o_fma_op1, 32'd0);
    chk("rst_op2", o_fma_op2, 32'd0);
    chk("rst_op3", o_fma_op3, 32'd0);
`ifdef FFLAGS_EN
    chk("rst_fflags", {27'b0, o_fflags}, 32'd0);
`endif
    i_reset = 1'b0; i_request = 1'b0;
    run_op(2'd0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h40E0_0000, 1, 1, 3, 1'b0, g1, g3, gr);
    chk("fmadd_op1", g1, 32'h4000_0000);
    chk("fmadd_op3", g3, 32'h3F80_0000);
    chk("fmadd_res", gr, 32'h40E0_0000);
    run_op(2'd1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h40A0_0000, 0, 1, 1, 1'b0, g1, g3, gr);
    chk("fmsub_op3", g3, 32'hBF80_0000);
    chk("fmsub_res", gr, 32'h40A0_0000);
    run_op(2'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'hC0E0_0000, 2, 1, 2, 1'b0, g1, g3, gr);
    chk("fnmadd_op1", g1, 32'hC000_0000);
    chk("fnmadd_op3", g3, 32'hBF80_0000);
    chk("fnmadd_res", gr, 32'hC0E0_0000);
    run_op(2'd2, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'hC0A0_0000, 1, 1, 1, 1'b0, g1, g3, gr);
    chk("fnmsub_op1", g1, 32'hC000_0000);
    chk("fnmsub_op3", g3, 32'h3F80_0000);
    run_op(2'd0, 32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'hFFC0_0000, 1, 1, 1, 1'b0, g1, g3, gr);
    chk("nan_canon", gr, 32'h7FC0_0000);
`ifdef FFLAGS_EN
    chk("fflags_inf_x_zero", {27'b0, o_fflags}, 32'h10);
`endif
    run_op(2'd3, 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0001, 0, 1, 1, 1'b0, g1, g3, gr);
    chk("neg_nan_op1", g1, 32'hFFC0_0000);
    chk("neg_zero_op3", g3, 32'h8000_0000);
    chk("snan_canon", gr, 32'h7FC0_0000);
    run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000, 0, 1, 1, 1'b0, g1, g3, gr);
    chk("inf_passthru", gr, 32'hFF80_0000);
    run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1, 3, 0, 1'b1, g1, g3, gr);
    chk("drop_early_res", gr, 32'h3F80_0000);
    @(negedge i_clock);
    i_op = 2'd0; i_rs1 = 32'h4000_0000; i_rs2 = 32'h4000_0000; i_rs3 = 32'h0; i_request = 1'b1;
    exp_op1 = 32'h4000_0000; exp_op2 = 32'h4000_0000; exp_op3 = 32'h0;
    @(negedge i_clock);
    chk("pre_reset_req", {31'b0, o_fma_request}, 32'd1);
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("mid_reset_req", {31'b0, o_fma_request}, 32'd0);
    chk("mid_reset_ready", {31'b0, o_ready}, 32'd0);
    @(negedge i_clock);
    chk("reset_wins_req", {31'b0, o_fma_request}, 32'd0);
    chk("reset_wins_op1", o_fma_op1, 32'd0);
    i_reset = 1'b0; i_request = 1'b0;
    run_op(2'd1, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1, 2, 1, 1'b0, g1, g3, gr);
    chk("post_reset_op3", g3, 32'hC000_0000);
    chk("post_reset_res", gr, 32'h4000_0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cpu_fpu_fused_issue.md
Name: cpu_fpu_fused_issue

Overview:
Requester-side sequencer for the multi-cycle single-precision fused multiply-add unit. It sits between the FPU decode/execute stage and the fused unit.
- Accepts a decoded fused op (FMADD/FMSUB/FNMSUB/FNMADD) and applies the operand sign manipulation for that op.
- Drives the unit's 4-phase request/ready handshake and captures the result.
- Canonicalises NaN results and presents the result upstream on the same 4-phase handshake.

Parameters:
CANONICAL_NAN, 32'h7FC00000, value substituted for any NaN result.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_request  in  1  upstream request; held high until o_ready seen
i_op  in  2  0=FMADD, 1=FMSUB, 2=FNMSUB, 3=FNMADD
i_rs1  in  32  multiplicand
i_rs2  in  32  multiplier
i_rs3  in  32  addend
o_ready  out  1  upstream result valid
o_result  out  32  upstream result
o_fflags  out  5  {NV,DZ,OF,UF,NX}; only present with FFLAGS_EN
o_fma_request  out  1  request to fused unit
o_fma_op1  out  32  unit operand 1
o_fma_op2  out  32  unit operand 2
o_fma_op3  out  32  unit operand 3
i_fma_ready  in  1  unit result valid
i_fma_result  in  32  unit result

Behaviour:
- Clock and reset: reset i_reset, synchronous, active-high; clock i_clock. All outputs are registered.
- Reset values: o_ready=0, o_result=0, o_fflags=0, o_fma_request=0, o_fma_op1/2/3=0. State returns to IDLE.
- IDLE, with i_request=1:
  - Latch operands into o_fma_op1..3:
    - op1 = i_rs1 with bit31 inverted for op 2 and op 3.
    - op2 = i_rs2 unchanged.
    - op3 = i_rs3 with bit31 inverted for op 1 and op 3.
  - Negation flips bit31 unconditionally, including on NaN and zero.
  - Set o_fma_request=1 and go to ISSUE. Operands are valid in the same cycle the request rises.
- ISSUE: hold o_fma_request and the operands stable.
  - On i_fma_ready=1: capture i_fma_result, drop o_fma_request, go to RELEASE.
- RELEASE: wait for i_fma_ready=0.
  - Never re-raise o_fma_request while i_fma_ready=1.
  - Then go to DONE: o_ready=1, o_result=captured value.
- NaN canonicalisation: if captured result bits[30:23]==255 and bits[22:0]!=0, o_result=CANONICAL_NAN. Example: 0xFFC00000 becomes 0x7FC00000.
- DONE: hold o_ready=1 and o_result stable while i_request=1.
  - On i_request=0: o_ready=0 next cycle, go to IDLE.
  - A new request is accepted only from IDLE, so back-to-back requests lose at least one idle cycle.
- Upstream drop mid-operation: if i_request falls during ISSUE or RELEASE, the downstream transaction still completes. DONE is entered, o_ready pulses for one cycle, then the block returns to IDLE.
- Latency: o_ready rises 2 cycles after the first cycle with i_fma_ready=1 (capture, release observed), plus any extra cycles i_fma_ready stays high.
- Reset mid-operation: o_fma_request drops on the next edge. The fused unit shares i_reset and also returns to idle. No result is produced.
- Simultaneous i_reset and i_request: reset wins and the request is not latched.

Optional Feature:
FFLAGS_EN
- With the macro defined, o_fflags is present. It is computed in IDLE from the latched, sign-adjusted operands and registered with o_result in DONE.
  - NV=1 if any operand is a signalling NaN (exp 255, mant!=0, bit22=0).
  - NV=1 if the product is inf*0.
  - NV=1 if the product is infinite and the addend is an infinity of opposite effective sign.
  - OF=1 if the result is infinite and no operand was infinite.
  - DZ, UF and NX are always 0.
- Without the macro, the o_fflags port and its logic are absent.

Decomposition:
- Shared package cpu_fpu_pkg holds:
  - fused op enum (FMADD/FMSUB/FNMSUB/FNMADD);
  - fflags bit indices;
  - float field constants (EXP_MAX=255, QNAN_BIT=22, CANONICAL_NAN).
- Optional sub-module cpu_fpu_classify: combinational 32-bit classifier with outputs is_zero, is_inf, is_nan, is_snan. It is used for NaN canonicalisation and FFLAGS_EN.

Test Plan:
- FMADD, rs1=0x40000000, rs2=0x40400000, rs3=0x3F800000, model returns 0x40E00000 -> op1..3 passed unchanged, o_result=0x40E00000, o_ready held until i_request falls.
- FMSUB with the same operands -> o_fma_op3=0xBF800000; model returns 0x40A00000 -> o_result=0x40A00000.
- FNMADD with the same operands -> o_fma_op1=0xC0000000, o_fma_op3=0xBF800000; result 0xC0E00000 passed through.
- Model returns 0xFFC00000 -> o_result=0x7FC00000. With FFLAGS_EN: rs1=0x7F800000, rs2=0x00000000 -> o_fflags=5'b10000.
- Model holds i_fma_ready high for 3 cycles -> o_fma_request stays 0 throughout, DONE only after i_fma_ready falls; i_request dropped during ISSUE -> single-cycle o_ready pulse, then IDLE.
- i_reset asserted in ISSUE -> o_fma_request=0 and o_ready=0 next cycle; a subsequent request completes normally.
